// File: rtl/encoder_sixteen_four_rr.sv
// Sequential 16-to-4 round-robin encoder: drains a multi-hot pending set one index per handshake.
// Optional macro ENC_PEND_COUNT_EN adds a registered popcount output pend_cnt.
module encoder_sixteen_four_rr #(
  parameter int N_ENT = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             req_load,
  input  logic [N_ENT-1:0] req_in,
  input  logic             idx_ready,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx_out,
  output logic [N_ENT-1:0] pending,
  output logic             idle
`ifdef ENC_PEND_COUNT_EN
  ,
  output logic [IDX_W:0]   pend_cnt
`endif
);

  logic [N_ENT-1:0] r_pending;
  logic             r_idx_valid;
  logic [IDX_W-1:0] r_idx_out;
  logic [IDX_W-1:0] r_rr_ptr;

  logic             w_accept;
  logic             w_load_out;
  logic [N_ENT-1:0] w_accept_mask;
  logic [N_ENT-1:0] w_pending_nx;
  logic [N_ENT-1:0] w_rot;
  logic             w_found;
  logic [IDX_W-1:0] w_offset;
  logic [IDX_W-1:0] w_pick;

  assign w_accept   = r_idx_valid & idx_ready;
  assign w_load_out = ~r_idx_valid | w_accept;

  // A same-cycle reload of the accepted bit wins because the OR is applied after the clear.
  assign w_pending_nx = (r_pending & ~w_accept_mask) | (req_load ? req_in : '0);

  // w_rot[k] is the request k places above rr_ptr; index arithmetic wraps mod 16.
  for (genvar gi = 0; gi < N_ENT; gi++) begin : g_rot
    logic [IDX_W-1:0] w_src;
    assign w_accept_mask[gi] = w_accept && (r_idx_out == IDX_W'(gi));
    assign w_src             = r_rr_ptr + IDX_W'(gi);
    assign w_rot[gi]         = w_pending_nx[w_src];
  end

  assign w_found = |w_rot;

  always_comb begin
    w_offset = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (w_rot[i]) w_offset = IDX_W'(i);
    end
  end

  assign w_pick = r_rr_ptr + w_offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_idx_valid <= 1'b0;
      r_idx_out   <= '0;
      r_rr_ptr    <= '0;
    end else if (clear) begin
      r_pending   <= '0;
      r_idx_valid <= 1'b0;
      r_idx_out   <= '0;
    end else begin
      r_pending <= w_pending_nx;
      if (w_load_out) begin
        r_idx_valid <= w_found;
        if (w_found) begin
          r_idx_out <= w_pick;
          r_rr_ptr  <= w_pick + IDX_W'(1);
        end
      end
    end
  end

`ifdef ENC_PEND_COUNT_EN
  logic [IDX_W:0] w_cnt_nx;
  logic [IDX_W:0] r_pend_cnt;

  always_comb begin
    w_cnt_nx = '0;
    for (int i = 0; i < N_ENT; i++) begin
      w_cnt_nx = w_cnt_nx + (IDX_W + 1)'(w_pending_nx[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) r_pend_cnt <= '0;
    else              r_pend_cnt <= w_cnt_nx;
  end

  assign pend_cnt = r_pend_cnt;
`endif

  assign idx_valid = r_idx_valid;
  assign idx_out   = r_idx_out;
  assign pending   = r_pending;
  assign idle      = (r_pending == '0) && !r_idx_valid;

endmodule

// File: doc/encoder_sixteen_four_rr.md
Name: encoder_sixteen_four_rr

Overview:
- Sequential 16-to-4 encoder: the inverse of the predictor's 4-to-16 index decoder.
- Collects a 16-bit multi-hot vector of pending PHT-entry update requests, one bit per predictor entry.
- Emits one 4-bit entry index at a time over a valid/ready handshake.
- Serves requests in round-robin order, so repeated mispredict updates cannot starve any PHT entry.

Parameters:
- N_ENT, 16, number of request lines; fixed at 16.
- IDX_W, 4, index width; fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush of all pending requests and the output
- req_load  input  1  when high, req_in is OR-merged into the pending set
- req_in  input  16  request vector; bit k requests entry k
- idx_ready  input  1  consumer accepts idx_out this cycle
- idx_valid  output  1  idx_out holds a valid entry index
- idx_out  output  4  encoded entry index
- pending  output  16  current pending request set, registered
- idle  output  1  high when pending==0 and idx_valid==0, combinational from registers

Behaviour:
- Reset (rst=1 at an edge): pending=16'h0000, idx_valid=0, idx_out=4'h0, rr_ptr=4'h0. rst has priority over clear and all other inputs.
- clear=1 at an edge (rst=0): same values as reset except rr_ptr, which is held. req_load in that cycle is ignored.
- accept = idx_valid & idx_ready.
- Next pending: pending_nx = (pending & ~(accept ? (1<<idx_out) : 0)) | (req_load ? req_in : 0).
- If req_in sets the bit being accepted in the same cycle, the new request wins and the bit stays set.
- Output register load condition: (!idx_valid | accept).
  - When loaded, idx_valid = (pending_nx != 0).
  - idx_out = round-robin pick from pending_nx.
  - If pending_nx==0: idx_valid=0 and idx_out holds its previous value.
- Output hold: while idx_valid & !idx_ready, idx_out and idx_valid stay stable. New requests only accumulate in pending.
- The presented bit stays in pending until accepted, so an index is never presented twice.
- Round-robin pick: the first set bit of pending_nx scanning upward from rr_ptr, wrapping 15->0.
- rr_ptr update: rr_ptr <= picked index + 1, mod 16, wrapping 15->0. Updated only when the output register loads with idx_valid=1.
- Latency: req_load at edge N with an empty output register gives idx_valid=1 in the cycle after edge N (1 cycle).
- Throughput: one index per cycle while idx_ready is held high.
- States (implicit in idx_valid and pending):
  - IDLE: pending==0, !idx_valid.
  - PRESENT: idx_valid.
  - PRESENT -> IDLE on the accept of the last pending bit, when no new load arrives.
- idx_ready while idx_valid=0 has no effect.
- req_in=0 with req_load=1 is a no-op.

Optional Feature:
- Macro: ENC_PEND_COUNT_EN.
- Defined: adds output pend_cnt[4:0], a registered popcount of pending_nx.
  - Reset/clear value: 0.
  - Range 0..16; a full pending set reads 16 (5'b10000).
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> pending=0, idx_valid=0, idx_out=0, idle=1.
- Round-robin and latency: req_load=1, req_in=16'h8011, idx_ready=1 -> next cycle idx_out=0, then 4, then 15; idx_valid drops after the third accept; pending ends at 0.
- Backpressure: load 16'h0006, idx_ready=0 for 3 cycles -> idx_out=1 stable, idx_valid=1. Then idx_ready=1 -> 1, then 2.
- Wrap-around: after index 14 is accepted (rr_ptr=15), load 16'h4003 -> order 0, 1, 14.
- Simultaneous accept and reload: idx_out=5 accepted while req_load with req_in=16'h0020 -> bit 5 remains pending and is re-presented after the other pending bits in RR order.
- Clear mid-operation: pending=16'hFFFF, idx_valid=1, assert clear with req_load=1 -> next cycle pending=0, idx_valid=0, idle=1; with ENC_PEND_COUNT_EN defined, pend_cnt=0.
